// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable duty-cycle clock divider.
package clk_div_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;

endpackage

// File: rtl/clk_div_cfg_shadow.sv
// One-entry configuration shadow: handshake, validity check, pending flag and cfg_err pulse.
module clk_div_cfg_shadow
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             apply,
    output logic             pending,
    output logic [CNT_W-1:0] sh_period,
    output logic [CNT_W-1:0] sh_high,
    output logic             cfg_err
);

    logic accept;
    logic period_ok;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & cfg_ready;
    assign period_ok = 32'(cfg_period) >= MIN_PERIOD;

    // accept and apply are mutually exclusive: accept needs pending low, apply needs it high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending   <= 1'b0;
            sh_period <= '0;
            sh_high   <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= accept & ~period_ok;
            if (accept && period_ok) begin
                pending   <= 1'b1;
                sh_period <= cfg_period;
                sh_high   <= cfg_high;
            end else if (apply) begin
                pending   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_div_duty.sv
// Programmable divided clock with registered output, low phase then high phase per period.
// Optional period counter output pcnt enabled by defining CLK_DIV_DUTY_PCNT_EN.
module clk_div_duty
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned PERIOD_RST = 10,
    parameter int unsigned HIGH_RST   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             clk_out,
    output logic             period_start,
    output logic             cfg_err
`ifdef CLK_DIV_DUTY_PCNT_EN
    ,
    output logic [15:0]      pcnt
`endif
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] per, per_nxt;
    logic [CNT_W-1:0] hi, hi_nxt;
    logic             clk_out_nxt;
    logic             ps_nxt;
    logic             apply;
    logic             pending;
    logic [CNT_W-1:0] sh_period;
    logic [CNT_W-1:0] sh_high;

    clk_div_cfg_shadow #(
        .CNT_W(CNT_W)
    ) u_shadow (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .apply      (apply),
        .pending    (pending),
        .sh_period  (sh_period),
        .sh_high    (sh_high),
        .cfg_err    (cfg_err)
    );

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        per_nxt   = per;
        hi_nxt    = hi;
        apply     = 1'b0;
        ps_nxt    = 1'b0;

        case (state)
            ST_IDLE: begin
                cnt_nxt = '0;
                if (pending) begin
                    apply   = 1'b1;
                    per_nxt = sh_period;
                    hi_nxt  = sh_high;
                end
                if (en) begin
                    state_nxt = ST_RUN;
                    ps_nxt    = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt == per - ONE) begin
                    cnt_nxt = '0;
                    if (pending) begin
                        apply   = 1'b1;
                        per_nxt = sh_period;
                        hi_nxt  = sh_high;
                    end
                    if (en) begin
                        ps_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Output is computed from the next count and next P/H so it can be registered
        clk_out_nxt = 1'b0;
        if (state_nxt == ST_RUN && hi_nxt != '0) begin
            if (hi_nxt >= per_nxt) begin
                clk_out_nxt = 1'b1;
            end else begin
                clk_out_nxt = (cnt_nxt >= per_nxt - hi_nxt);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            per          <= CNT_W'(PERIOD_RST);
            hi           <= CNT_W'(HIGH_RST);
            clk_out      <= 1'b0;
            period_start <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            per          <= per_nxt;
            hi           <= hi_nxt;
            clk_out      <= clk_out_nxt;
            period_start <= ps_nxt;
        end
    end

`ifdef CLK_DIV_DUTY_PCNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt <= '0;
        end else if (ps_nxt) begin
            pcnt <= pcnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/clk_div_duty.md
CLK_DIV_DUTY -- requirements
Module: clk_div_duty

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the period/high-time counter width in bits.
REQ-002 The block SHALL have parameter PERIOD_RST, default 10, giving the period in clk cycles loaded at reset.
REQ-003 The block SHALL have parameter HIGH_RST, default 4, giving the high time in clk cycles loaded at reset (40% duty).
REQ-004 The block SHALL have the ports below, in this order:
- clk  input  1  single block clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  run request.
- cfg_valid  input  1  new configuration offered.
- cfg_ready  output  1  configuration slot free.
- cfg_period  input  CNT_W  requested period in cycles.
- cfg_high  input  CNT_W  requested high time in cycles.
- clk_out  output  1  registered divided clock.
- period_start  output  1  one-cycle pulse on the first cycle of each period.
- cfg_err  output  1  one-cycle pulse when a configuration is rejected.

Function
REQ-005 The block SHALL implement two states: IDLE (cnt=0, clk_out=0) and RUN.
REQ-006 IDLE SHALL go to RUN on the edge where en=1; the first RUN cycle SHALL have cnt=0 and period_start=1.
REQ-007 In RUN, cnt SHALL step 0..P-1 and then wrap to 0; P and H are the active period and high time.
REQ-008 At cnt=k, clk_out SHALL be 1 iff k >= P-H. The low phase comes first, then the high phase; the output is registered with no combinational path.
REQ-009 If H=0, clk_out SHALL stay 0. If H>=P, clk_out SHALL stay 1 for the whole RUN.
REQ-010 If en=0 in RUN, the current period SHALL complete; on the wrap the block SHALL enter IDLE (no runt pulse).
REQ-011 If en returns to 1 before the wrap, the block SHALL stay in RUN.
REQ-012 The configuration handshake SHALL be accepted on cfg_valid & cfg_ready; cfg_ready SHALL equal NOT pending.
REQ-013 An accepted configuration SHALL be checked as follows:
- cfg_period < 2: reject; pulse cfg_err the next cycle; no state change.
- otherwise: store into a one-entry shadow and set pending.
REQ-014 In IDLE, a pending configuration SHALL be applied on the next edge and pending cleared.
REQ-015 In RUN, a pending configuration SHALL be applied on the wrap edge, so the new period starts with the new P/H.
REQ-016 A configuration accepted on the same cycle as a wrap SHALL be applied at the following wrap.
REQ-017 The arithmetic SHALL be unsigned CNT_W bits. P-H SHALL be computed only when H<P, so no underflow is possible.

Reset
REQ-018 Asserting rst SHALL immediately force: state=IDLE, cnt=0, clk_out=0, period_start=0, cfg_err=0, pending=0, cfg_ready=1, P=PERIOD_RST, H=HIGH_RST.
REQ-019 Reset asserted mid-period SHALL abort that period with no completion.
REQ-020 Reset deassertion SHALL be synchronised by the integrator; the block itself has no reset synchroniser.

Configuration
REQ-021 With CLK_DIV_DUTY_PCNT_EN defined, the block SHALL add output pcnt[15:0]. pcnt counts period_start pulses, wraps at 0xFFFF->0, resets to 0, and holds its value in IDLE.
REQ-022 Without CLK_DIV_DUTY_PCNT_EN, the pcnt port and its counter SHALL be absent.

Structure
REQ-023 A shared package clk_div_pkg SHALL hold the state enum (ST_IDLE, ST_RUN) and the constant MIN_PERIOD=2.
REQ-024 One sub-module, clk_div_cfg_shadow, SHALL hold the shadow register, the pending flag, the validity check and cfg_err.
REQ-025 The counter, FSM and output logic SHALL live in the top module.

Verification
REQ-026 Reset defaults: reset, then en=1 -> clk_out 6 cycles low, 4 cycles high, repeating; period_start every 10 cycles.
REQ-027 Reconfiguration: cfg 8/2 accepted mid-period -> current 10-cycle period completes, then 6 low / 2 high; cfg_ready=0 until applied.
REQ-028 Rejected configuration: cfg_period=1 -> cfg_err pulse one cycle later; waveform unchanged; cfg_ready stays 1.
REQ-029 Duty extremes: cfg H=0 then H=12 with P=12 -> clk_out constantly 0, then constantly 1; period_start still every 12 cycles.
REQ-030 Stop and abort: en drops at cnt=3 -> IDLE entered only at the wrap after cnt=9. Separately, rst at cnt=7 -> clk_out=0 immediately and P/H back to 10/4.
REQ-031 Counter option: with CLK_DIV_DUTY_PCNT_EN and pcnt preset by running 65536 periods -> pcnt wraps to 0.
